net_sequencer: RTL
==================

NET_SEQUENCER -- requirements
Module: net_sequencer

Interface
REQ-001 The block SHALL have parameter LAYERS, default 3, giving the number of layer instances sequenced (1..16).
REQ-002 The block SHALL have parameter NUM_W, default 16, giving the fixed-point word width.
REQ-003 The block SHALL have parameter RAM_ADDR_W, default 8, giving the shared RAM address width.
REQ-004 The block SHALL have parameter TIMEOUT, default 1023, giving the maximum cycles a layer may stay busy.
REQ-005 The block SHALL have the following ports:
  clk  in  1  sole clock, rising edge.
  reset  in  1  synchronous, active-high reset.
  enable  in  1  global advance qualifier.
  run_f  in  1  start forward pass.
  run_b  in  1  start backward pass.
  busy  out  1  pass in progress.
  done  out  1  one-cycle pass-complete pulse.
  error  out  1  sticky timeout flag.
  cur_layer  out  4  index of the granted layer.
  layer_start_f / layer_start_b  out  LAYERS  per-layer start strobes.
  layer_ready_in  out  LAYERS  per-layer ready_f_in/ready_b_in grant.
  layer_ready  in  LAYERS  per-layer ready_out.
  layer_mult_en  in  LAYERS  per-layer multiplier enable.
  layer_mult_v1 / layer_mult_v2  in  LAYERS*NUM_W  per-layer operands.
  mult_en  out  1  shared multiplier enable.
  mult_v1 / mult_v2  out  NUM_W  shared multiplier operands.
  layer_ram_write  in  LAYERS  per-layer RAM write enable.
  layer_ram_addr_read / layer_ram_addr_write  in  LAYERS*RAM_ADDR_W  per-layer RAM addresses.
  layer_ram_data_write  in  LAYERS*NUM_W  per-layer RAM write data.
  ram_write  out  1  shared RAM write enable.
  ram_addr_read / ram_addr_write  out  RAM_ADDR_W  shared RAM addresses.
  ram_data_write  out  NUM_W  shared RAM write data.

Function
REQ-006 The FSM SHALL have states IDLE, ISSUE, ARM, WAIT, NEXT and ERR; nothing advances while enable=0, and strobes SHALL be 0 while enable=0.
REQ-007 In IDLE, run_f=1 SHALL load cur_layer=0, dir=forward and go to ISSUE; run_b=1 alone SHALL load cur_layer=LAYERS-1, dir=backward and go to ISSUE; run_f SHALL win when both are high.
REQ-008 run_f and run_b SHALL be ignored outside IDLE.
REQ-009 ISSUE SHALL last one cycle and assert layer_start_f[cur] (forward) or layer_start_b[cur] (backward); next state SHALL be ARM.
REQ-010 ARM SHALL wait for layer_ready[cur]=0, then go to WAIT.
REQ-011 WAIT SHALL wait for layer_ready[cur]=1, then go to NEXT.
REQ-012 NEXT SHALL go to IDLE with done=1 for one cycle when cur is the last layer in the pass direction; otherwise it SHALL step cur (+1 forward, -1 backward) and go to ISSUE.
REQ-013 layer_ready_in[cur] SHALL be 1 in ARM and WAIT; all other bits SHALL be 0.
REQ-014 In ARM and WAIT, mult_en, mult_v1 and mult_v2 SHALL be combinational selects of slice cur; elsewhere they SHALL be 0.
REQ-015 In ARM and WAIT, ram_write, ram_addr_read, ram_addr_write and ram_data_write SHALL be combinational selects of slice cur; elsewhere they SHALL be 0.
REQ-016 Non-granted layers' bus requests SHALL be dropped, never queued.
REQ-017 A cycle counter SHALL clear on entry to ARM and count enabled cycles in ARM and WAIT.
REQ-018 When the counter reaches TIMEOUT, the FSM SHALL go to ERR, set error=1 and drop busy.
REQ-019 ERR SHALL be left only by reset.
REQ-020 busy SHALL be 1 in ISSUE, ARM, WAIT and NEXT.
REQ-021 Latency: run_f sampled at cycle 0 SHALL give layer_start_f[0]=1 at cycle 1.
REQ-022 With LAYERS=1, NEXT SHALL go directly to IDLE with done=1.

Reset
REQ-023 Reset SHALL put the FSM in IDLE, clear cur_layer and the counter, and drive busy, done, error, all strobes, all grants and all shared-bus outputs to 0.
REQ-024 Reset mid-pass SHALL abandon the pass with no done pulse.
REQ-025 Reset SHALL take priority over enable.

Structure
REQ-026 The FSM state enum and the default NUM_W and RAM_ADDR_W constants SHALL live in shared package net_pkg.
REQ-027 Slice selection SHALL be a sub-module bus_mux, parameterised by width and count, instantiated once per muxed bus.

Verification
REQ-028 Bench: LAYERS=3 with layer models busy 5 cycles; run_f at cycle 0 -> start_f strobes in order 0,1,2, at most one grant high at a time, one done pulse, busy returns to 0.
REQ-029 Bench: run_b -> start_b strobes in order 2,1,0, then done; run_f and run_b high together -> forward order.
REQ-030 Bench: layer 1 drives mult_v1=0x0100 and layer 0 drives 0x7FFF while layer 1 is granted -> mult_v1=0x0100; in IDLE -> mult_v1=0.
REQ-031 Bench: TIMEOUT=20 and layer 1 never returns ready -> error=1 on the 20th WAIT cycle; run_f then ignored until reset.
REQ-032 Bench: enable=0 for 7 cycles during WAIT -> state and counter frozen, strobes 0; reset asserted in WAIT -> IDLE and all outputs 0 next cycle.

Source files
------------

// File: rtl/net_pkg.sv
// Shared types and defaults for the layer sequencer and its bus fabric.
package net_pkg;

    localparam int unsigned NUM_W_DEF      = 16;
    localparam int unsigned RAM_ADDR_W_DEF = 8;
    // Layer index width; caps the sequencer at 16 layers.
    localparam int unsigned CUR_W          = 4;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StArm,
        StWait,
        StNext,
        StErr
    } state_e;

    typedef enum logic {
        DirFwd,
        DirBwd
    } dir_e;

    // True when cur is the final layer of a pass in direction dir.
    function automatic logic is_last_layer(input dir_e dir,
                                           input logic [CUR_W-1:0] cur,
                                           input logic [CUR_W-1:0] last_idx);
        return (dir == DirFwd) ? (cur == last_idx) : (cur == '0);
    endfunction

endpackage

// File: rtl/net_sequencer_if.sv
// Control, per-layer and shared-bus signals of the layer sequencer.
interface net_sequencer_if
    import net_pkg::*;
#(
    parameter int unsigned LAYERS     = 3,
    parameter int unsigned NUM_W      = NUM_W_DEF,
    parameter int unsigned RAM_ADDR_W = RAM_ADDR_W_DEF
);
    logic                         enable;
    logic                         run_f;
    logic                         run_b;
    logic                         busy;
    logic                         done;
    logic                         error;
    logic [CUR_W-1:0]             cur_layer;

    logic [LAYERS-1:0]            layer_start_f;
    logic [LAYERS-1:0]            layer_start_b;
    logic [LAYERS-1:0]            layer_ready_in;
    logic [LAYERS-1:0]            layer_ready;

    logic [LAYERS-1:0]            layer_mult_en;
    logic [LAYERS*NUM_W-1:0]      layer_mult_v1;
    logic [LAYERS*NUM_W-1:0]      layer_mult_v2;
    logic                         mult_en;
    logic [NUM_W-1:0]             mult_v1;
    logic [NUM_W-1:0]             mult_v2;

    logic [LAYERS-1:0]            layer_ram_write;
    logic [LAYERS*RAM_ADDR_W-1:0] layer_ram_addr_read;
    logic [LAYERS*RAM_ADDR_W-1:0] layer_ram_addr_write;
    logic [LAYERS*NUM_W-1:0]      layer_ram_data_write;
    logic                         ram_write;
    logic [RAM_ADDR_W-1:0]        ram_addr_read;
    logic [RAM_ADDR_W-1:0]        ram_addr_write;
    logic [NUM_W-1:0]             ram_data_write;

    // Sequencer side: owns strobes, grants and the shared buses.
    modport master (
        input  enable, run_f, run_b, layer_ready,
        input  layer_mult_en, layer_mult_v1, layer_mult_v2,
        input  layer_ram_write, layer_ram_addr_read, layer_ram_addr_write, layer_ram_data_write,
        output busy, done, error, cur_layer,
        output layer_start_f, layer_start_b, layer_ready_in,
        output mult_en, mult_v1, mult_v2,
        output ram_write, ram_addr_read, ram_addr_write, ram_data_write
    );

    // Environment side: layers, multiplier and RAM.
    modport slave (
        output enable, run_f, run_b, layer_ready,
        output layer_mult_en, layer_mult_v1, layer_mult_v2,
        output layer_ram_write, layer_ram_addr_read, layer_ram_addr_write, layer_ram_data_write,
        input  busy, done, error, cur_layer,
        input  layer_start_f, layer_start_b, layer_ready_in,
        input  mult_en, mult_v1, mult_v2,
        input  ram_write, ram_addr_read, ram_addr_write, ram_data_write
    );

endinterface

// File: rtl/bus_mux.sv
// Selects one WIDTH-bit slice out of COUNT packed slices; zero when not granted.
module bus_mux #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned COUNT = 1,
    parameter int unsigned SEL_W = 4
) (
    input  logic [COUNT*WIDTH-1:0] data,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   grant,
    output logic [WIDTH-1:0]       slice
);

    // Out-of-range selects fall through to zero, so non-granted requests vanish.
    always_comb begin
        slice = '0;
        if (grant) begin
            for (int unsigned i = 0; i < COUNT; i++) begin
                if (32'(sel) == i) begin
                    slice = data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/net_sequencer.sv
// Runs a forward or backward pass over LAYERS layers, granting the shared
// multiplier and RAM to exactly one layer at a time, with a busy timeout.
module net_sequencer
    import net_pkg::*;
#(
    parameter int unsigned LAYERS     = 3,
    parameter int unsigned NUM_W      = NUM_W_DEF,
    parameter int unsigned RAM_ADDR_W = RAM_ADDR_W_DEF,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic            clk,
    input  logic            reset,
    net_sequencer_if.master bus
);

    localparam int unsigned      CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CUR_W-1:0] LAST_IDX = CUR_W'(LAYERS - 1);

    state_e           state_q;
    dir_e             dir_q;
    logic [CUR_W-1:0] cur_q;
    logic [CNT_W-1:0] cnt_q;
    logic             start_q;
    logic             done_q;
    logic             error_q;

    logic [LAYERS-1:0] cur_onehot;
    logic              granted;
    logic              ready_cur;
    logic [CNT_W-1:0]  cnt_inc;
    logic              timeout_hit;
    logic              last_layer;

    // One-hot decode of the granted layer index.
    always_comb begin
        cur_onehot = '0;
        for (int unsigned i = 0; i < LAYERS; i++) begin
            cur_onehot[i] = (32'(cur_q) == i);
        end
    end

    assign granted     = (state_q == StArm) || (state_q == StWait);
    assign ready_cur   = |(bus.layer_ready & cur_onehot);
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));
    assign last_layer  = is_last_layer(dir_q, cur_q, LAST_IDX);

    // Pass sequencing FSM; all state and pulse outputs update here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            dir_q   <= DirFwd;
            cur_q   <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.enable) begin
                // start_q only drops on an enabled edge so a stalled ISSUE keeps its strobe.
                start_q <= 1'b0;
                unique case (state_q)
                    StIdle: begin
                        if (bus.run_f) begin
                            cur_q   <= '0;
                            dir_q   <= DirFwd;
                            start_q <= 1'b1;
                            state_q <= StIssue;
                        end else if (bus.run_b) begin
                            cur_q   <= LAST_IDX;
                            dir_q   <= DirBwd;
                            start_q <= 1'b1;
                            state_q <= StIssue;
                        end
                    end
                    StIssue: begin
                        cnt_q   <= '0;
                        state_q <= StArm;
                    end
                    StArm, StWait: begin
                        cnt_q <= cnt_inc;
                        if (timeout_hit) begin
                            error_q <= 1'b1;
                            state_q <= StErr;
                        end else if (state_q == StArm && !ready_cur) begin
                            state_q <= StWait;
                        end else if (state_q == StWait && ready_cur) begin
                            state_q <= StNext;
                        end
                    end
                    StNext: begin
                        if (last_layer) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            cur_q   <= (dir_q == DirFwd) ? cur_q + 4'd1 : cur_q - 4'd1;
                            start_q <= 1'b1;
                            state_q <= StIssue;
                        end
                    end
                    StErr: begin
                        state_q <= StErr;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.busy           = (state_q == StIssue) || granted || (state_q == StNext);
    assign bus.done           = done_q;
    assign bus.error          = error_q;
    assign bus.cur_layer      = cur_q;
    assign bus.layer_start_f  = (bus.enable && start_q && dir_q == DirFwd) ? cur_onehot : '0;
    assign bus.layer_start_b  = (bus.enable && start_q && dir_q == DirBwd) ? cur_onehot : '0;
    assign bus.layer_ready_in = granted ? cur_onehot : '0;

    bus_mux #(.WIDTH(1), .COUNT(LAYERS), .SEL_W(CUR_W)) u_mux_mult_en (
        .data  (bus.layer_mult_en),
        .sel   (cur_q),
        .grant (granted),
        .slice (bus.mult_en)
    );

    bus_mux #(.WIDTH(NUM_W), .COUNT(LAYERS), .SEL_W(CUR_W)) u_mux_mult_v1 (
        .data  (bus.layer_mult_v1),
        .sel   (cur_q),
        .grant (granted),
        .slice (bus.mult_v1)
    );

    bus_mux #(.WIDTH(NUM_W), .COUNT(LAYERS), .SEL_W(CUR_W)) u_mux_mult_v2 (
        .data  (bus.layer_mult_v2),
        .sel   (cur_q),
        .grant (granted),
        .slice (bus.mult_v2)
    );

    bus_mux #(.WIDTH(1), .COUNT(LAYERS), .SEL_W(CUR_W)) u_mux_ram_write (
        .data  (bus.layer_ram_write),
        .sel   (cur_q),
        .grant (granted),
        .slice (bus.ram_write)
    );

    bus_mux #(.WIDTH(RAM_ADDR_W), .COUNT(LAYERS), .SEL_W(CUR_W)) u_mux_ram_addr_read (
        .data  (bus.layer_ram_addr_read),
        .sel   (cur_q),
        .grant (granted),
        .slice (bus.ram_addr_read)
    );

    bus_mux #(.WIDTH(RAM_ADDR_W), .COUNT(LAYERS), .SEL_W(CUR_W)) u_mux_ram_addr_write (
        .data  (bus.layer_ram_addr_write),
        .sel   (cur_q),
        .grant (granted),
        .slice (bus.ram_addr_write)
    );

    bus_mux #(.WIDTH(NUM_W), .COUNT(LAYERS), .SEL_W(CUR_W)) u_mux_ram_data_write (
        .data  (bus.layer_ram_data_write),
        .sel   (cur_q),
        .grant (granted),
        .slice (bus.ram_data_write)
    );

endmodule
